step_sequencer: RTL and testbench

Command front-end for the step accumulator: accepts ADD/SUB/CLR commands over a valid/ready interface, buffers them in a small FIFO, and replays each one as the exact `ctrl`/`step` cycle pattern the accumulator's one-hot FSM expects. It drives the accumulator's `ctrl` and `step` inputs directly, shares its `clk`/`rst`, and keeps a shadow copy of the accumulator's `out` for status and checking.

---
 rtl/step_sequencer.sv | 168 ++++++++++++++++
 tb/tb_step_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Command front-end for the step accumulator: buffers ADD/SUB/CLR commands in a
// small FIFO and replays each as the ctrl/step phase pattern the accumulator expects,
// tracking the accumulator's expected output in a shadow register.
module step_sequencer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_amt,
   output logic       ctrl,
   output logic [3:0] step,
   output logic [3:0] shadow,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpClr = 2'b10;
   localparam logic [1:0] OpRsv = 2'b11;

   typedef enum logic [1:0] {StIdle, StP1, StP2, StP3} state_e;

   // FIFO storage and pointers
   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Sequencer state
   state_e     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [3:0] amt_q, amt_d;
   logic [3:0] shadow_q, shadow_d;
   logic       ctrl_q, ctrl_d;
   logic [3:0] step_q, step_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       push, pop, empty, full, finish;
   logic [1:0] head_op;
   logic [3:0] head_amt;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign head_op   = mem_q[rd_ptr_q][5:4];
   assign head_amt  = mem_q[rd_ptr_q][3:0];

   assign ctrl   = ctrl_q;
   assign step   = step_q;
   assign shadow = shadow_q;
   assign done   = done_q;
   assign err    = err_q;
   assign busy   = (state_q != StIdle) || !empty;

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   // Phase sequencing, pop decision, shadow update and next registered outputs
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      amt_d    = amt_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      pop      = 1'b0;
      finish   = 1'b0;
      ctrl_d   = 1'b0;
      step_d   = 4'd0;

      unique case (state_q)
         StIdle: ;
         StP1: state_d = StP2;
         StP2: begin
            if (op_q == OpClr) begin
               shadow_d = 4'd0;
               done_d   = 1'b1;
               finish   = 1'b1;
            end else begin
               state_d = StP3;
            end
         end
         StP3: begin
            shadow_d = (op_q == OpAdd) ? shadow_q + amt_q : shadow_q - amt_q;
            done_d   = 1'b1;
            finish   = 1'b1;
         end
      endcase

      if (state_q == StIdle || finish) begin
         state_d = StIdle;
         if (!empty) begin
            if (head_op == OpRsv) begin
               // A reserved op is only consumed from idle so err never meets done
               if (state_q == StIdle) begin
                  pop   = 1'b1;
                  err_d = 1'b1;
               end
            end else begin
               pop     = 1'b1;
               op_d    = head_op;
               amt_d   = head_amt;
               state_d = StP1;
            end
         end
      end

      unique case (state_d)
         StIdle: ctrl_d = 1'b0;
         StP1:   ctrl_d = 1'b1;
         StP2:   ctrl_d = (op_d != OpClr);
         StP3:   ctrl_d = (op_d == OpAdd);
      endcase
      if (state_d != StIdle && op_d != OpClr) step_d = amt_d;
   end

   // Command storage; no reset needed since pointers gate validity
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_amt};
   end

   // State registers with synchronous reset shared with the accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= StIdle;
         op_q     <= 2'b00;
         amt_q    <= 4'd0;
         shadow_q <= 4'd0;
         ctrl_q   <= 1'b0;
         step_q   <= 4'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         op_q     <= op_d;
         amt_q    <= amt_d;
         shadow_q <= shadow_d;
         ctrl_q   <= ctrl_d;
         step_q   <= step_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: per-cycle vector table plus hand-written
// reset checks.
module tb_step_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_amt;
   logic       ctrl;
   logic [3:0] step;
   logic [3:0] shadow;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;

   step_sequencer #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .ctrl      (ctrl),
      .step      (step),
      .shadow    (shadow),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [1:0] op;
      logic [3:0] amt;
      logic       ctrl;
      logic [3:0] step;
      logic [3:0] sh;
      logic       done;
      logic       err;
      logic       busy;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [1:0] op, logic [3:0] amt, logic c,
                               logic [3:0] s, logic [3:0] sh, logic d, logic e,
                               logic b, logic r);
      vec_t x;
      x.v = v; x.op = op; x.amt = amt; x.ctrl = c; x.step = s; x.sh = sh;
      x.done = d; x.err = e; x.busy = b; x.rdy = r;
      return x;
   endfunction

   // Idle cycle with no command offered
   function automatic vec_t nv(logic c, logic [3:0] s, logic [3:0] sh, logic d,
                               logic e, logic b, logic r);
      return mk(1'b0, 2'b00, 4'd0, c, s, sh, d, e, b, r);
   endfunction

   task automatic check(string name, logic c, logic [3:0] s, logic [3:0] sh, logic d,
                        logic e, logic b, logic r);
      logic [14:0] act, exp;
      act = {ctrl, step, shadow, done, err, busy, cmd_ready};
      exp = {c, s, sh, d, e, b, r};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got ctrl=%b step=%0d shadow=%0d done=%b err=%b busy=%b rdy=%b, want ctrl=%b step=%0d shadow=%0d done=%b err=%b busy=%b rdy=%b",
                  name, ctrl, step, shadow, done, err, busy, cmd_ready,
                  c, s, sh, d, e, b, r);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Sequence A: ADD 5
      vecs.push_back(mk(1, 2'd0, 4'd5, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 5, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 5, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 5, 0, 0, 0, 1, 1));
      vecs.push_back(nv(0, 0, 5, 1, 0, 0, 1));
      vecs.push_back(nv(0, 0, 5, 0, 0, 0, 1));
      // Sequence B: CLR (amt ignored), ADD 3, SUB 7 back-to-back
      vecs.push_back(mk(1, 2'd2, 4'd9, 0, 0, 5, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd0, 4'd3, 1, 0, 5, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd1, 4'd7, 0, 0, 5, 0, 0, 1, 1));
      vecs.push_back(nv(1, 3, 0, 1, 0, 1, 1));
      vecs.push_back(nv(1, 3, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 3, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 7, 3, 1, 0, 1, 1));
      vecs.push_back(nv(1, 7, 3, 0, 0, 1, 1));
      vecs.push_back(nv(0, 7, 3, 0, 0, 1, 1));
      vecs.push_back(nv(0, 0, 12, 1, 0, 0, 1));
      vecs.push_back(nv(0, 0, 12, 0, 0, 0, 1));
      // Sequence C: ADD 1, reserved op, ADD 1
      vecs.push_back(mk(1, 2'd0, 4'd1, 0, 0, 12, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd3, 4'd0, 1, 1, 12, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd0, 4'd1, 1, 1, 12, 0, 0, 1, 1));
      vecs.push_back(nv(1, 1, 12, 0, 0, 1, 1));
      vecs.push_back(nv(0, 0, 13, 1, 0, 1, 1));
      vecs.push_back(nv(0, 0, 13, 0, 1, 1, 1));
      vecs.push_back(nv(1, 1, 13, 0, 0, 1, 1));
      vecs.push_back(nv(1, 1, 13, 0, 0, 1, 1));
      vecs.push_back(nv(1, 1, 13, 0, 0, 1, 1));
      vecs.push_back(nv(0, 0, 14, 1, 0, 0, 1));
      vecs.push_back(nv(0, 0, 14, 0, 0, 0, 1));
      // Sequence D: fill the FIFO; the ADD 15 offered while full must be dropped
      vecs.push_back(mk(1, 2'd0, 4'd1, 0, 0, 14, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd0, 4'd2, 1, 1, 14, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd1, 4'd3, 1, 1, 14, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd2, 4'd6, 1, 1, 14, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2'd0, 4'd4, 1, 2, 15, 1, 0, 1, 1));
      vecs.push_back(mk(1, 2'd0, 4'd5, 1, 2, 15, 0, 0, 1, 0));
      vecs.push_back(mk(1, 2'd0, 4'd15, 1, 2, 15, 0, 0, 1, 0));
      vecs.push_back(nv(1, 3, 1, 1, 0, 1, 1));
      vecs.push_back(nv(1, 3, 1, 0, 0, 1, 1));
      vecs.push_back(nv(0, 3, 1, 0, 0, 1, 1));
      vecs.push_back(nv(1, 0, 14, 1, 0, 1, 1));
      vecs.push_back(nv(0, 0, 14, 0, 0, 1, 1));
      vecs.push_back(nv(1, 4, 0, 1, 0, 1, 1));
      vecs.push_back(nv(1, 4, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 4, 0, 0, 0, 1, 1));
      vecs.push_back(nv(1, 5, 4, 1, 0, 1, 1));
      vecs.push_back(nv(1, 5, 4, 0, 0, 1, 1));
      vecs.push_back(nv(1, 5, 4, 0, 0, 1, 1));
      vecs.push_back(nv(0, 0, 9, 1, 0, 0, 1));
      vecs.push_back(nv(0, 0, 9, 0, 0, 0, 1));

      // Reset state
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_amt = 4'd0;
      tick();
      tick();
      check("reset", 0, 0, 0, 0, 0, 0, 1);
      rst = 1'b0;

      // Table-driven vectors: drive inputs, then check state after the edge
      for (int i = 0; i < vecs.size(); i++) begin
         cmd_valid = vecs[i].v;
         cmd_op    = vecs[i].op;
         cmd_amt   = vecs[i].amt;
         tick();
         check($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].step, vecs[i].sh,
               vecs[i].done, vecs[i].err, vecs[i].busy, vecs[i].rdy);
      end

      // Reset during P2 of a SUB with two commands queued
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_amt = 4'd5;
      tick();
      cmd_op = 2'd0; cmd_amt = 4'd1;
      tick();
      cmd_op = 2'd0; cmd_amt = 4'd2;
      tick();
      check("mid_sub_p2", 1, 5, 9, 0, 0, 1, 1);
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("mid_reset", 0, 0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("post_reset%0d", i), 0, 0, 0, 0, 0, 0, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
